// File: rtl/ex_stage_unit.sv
// Execute stage for the WISC-S25 pipeline: ALU with saturating arithmetic,
// Z/N/V flag register and the EX/MEM boundary register.
module ex_stage_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] ID_EX_PC_next,
    input  logic [37:0] ID_EX_EX_signals,
    input  logic [17:0] ID_EX_MEM_signals,
    input  logic [7:0]  ID_EX_WB_signals,
    output logic [15:0] EX_MEM_PC_next,
    output logic [15:0] EX_MEM_ALU_out,
    output logic [17:0] EX_MEM_MEM_signals,
    output logic [7:0]  EX_MEM_WB_signals,
    output logic        ZF,
    output logic        NF,
    output logic        VF
);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;

    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        z_en, nv_en;

    assign alu_a  = ID_EX_EX_signals[37:22];
    assign alu_b  = ID_EX_EX_signals[21:6];
    assign alu_op = ID_EX_EX_signals[5:2];
    assign z_en   = ID_EX_EX_signals[1];
    assign nv_en  = ID_EX_EX_signals[0];

    function automatic logic [15:0] paddsb(input logic [15:0] a, input logic [15:0] b);
        logic [3:0]  s;
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = a[4*i +: 4] + b[4*i +: 4];
            if ((a[4*i+3] == b[4*i+3]) && (s[3] != a[4*i+3]))
                r[4*i +: 4] = a[4*i+3] ? 4'h8 : 4'h7;
            else
                r[4*i +: 4] = s;
        end
        return r;
    endfunction

    logic [15:0] sum, diff, sll_res, sra_res, ror_res;
    logic [8:0]  red_hi, red_lo;
    logic [9:0]  red_sum;
    logic        add_ovf, sub_ovf;

    assign sum     = alu_a + alu_b;
    assign diff    = alu_a - alu_b;
    // Signed overflow: operands agree (add) or differ (sub) in sign and the result sign flips.
    assign add_ovf = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
    assign sub_ovf = (alu_a[15] != alu_b[15]) && (diff[15] != alu_a[15]);

    assign red_hi  = {alu_a[15], alu_a[15:8]} + {alu_b[15], alu_b[15:8]};
    assign red_lo  = {alu_a[7], alu_a[7:0]} + {alu_b[7], alu_b[7:0]};
    assign red_sum = {red_hi[8], red_hi} + {red_lo[8], red_lo};

    assign sll_res = alu_a << alu_b[3:0];
    assign sra_res = $signed(alu_a) >>> alu_b[3:0];
    // A shift of 16 on the left half clears it, so an amount of 0 passes A through.
    assign ror_res = (alu_a >> alu_b[3:0]) | (alu_a << (5'd16 - {1'b0, alu_b[3:0]}));

    logic [15:0] alu_d;
    logic        sat_d;

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        alu_d = '0;
        sat_d = 1'b0;
        case (alu_op)
            OP_ADD: begin
                sat_d = add_ovf;
                alu_d = add_ovf ? (alu_a[15] ? 16'h8000 : 16'h7FFF) : sum;
            end
            OP_SUB: begin
                sat_d = sub_ovf;
                alu_d = sub_ovf ? (alu_a[15] ? 16'h8000 : 16'h7FFF) : diff;
            end
            OP_XOR:        alu_d = alu_a ^ alu_b;
            OP_RED:        alu_d = {{6{red_sum[9]}}, red_sum};
            OP_SLL:        alu_d = sll_res;
            OP_SRA:        alu_d = sra_res;
            OP_ROR:        alu_d = ror_res;
            OP_PADDSB:     alu_d = paddsb(alu_a, alu_b);
            OP_LW, OP_SW:  alu_d = sum;
            OP_LLB:        alu_d = {alu_a[15:8], alu_b[7:0]};
            OP_LHB:        alu_d = {alu_b[7:0], alu_a[7:0]};
            default:       alu_d = '0;
        endcase
    end

    logic zf_d, nf_d, vf_d;

    assign zf_d = (alu_d == 16'h0000);
    assign nf_d = alu_d[15];
    assign vf_d = sat_d;

    logic [15:0] pc_q, alu_q;
    logic [17:0] mem_q;
    logic [7:0]  wb_q;
    logic        zf_q, nf_q, vf_q;

    // Flush beats stall: the bubble goes in and PC_next still advances; flags never change on a flush.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            pc_q  <= '0;
            alu_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            zf_q  <= 1'b0;
            nf_q  <= 1'b0;
            vf_q  <= 1'b0;
        end else if (flush) begin
            pc_q  <= ID_EX_PC_next;
            alu_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!stall) begin
            pc_q  <= ID_EX_PC_next;
            alu_q <= alu_d;
            mem_q <= ID_EX_MEM_signals;
            wb_q  <= ID_EX_WB_signals;
            if (z_en) zf_q <= zf_d;
            if (nv_en) begin
                nf_q <= nf_d;
                vf_q <= vf_d;
            end
        end
    end

    assign EX_MEM_PC_next     = pc_q;
    assign EX_MEM_ALU_out     = alu_q;
    assign EX_MEM_MEM_signals = mem_q;
    assign EX_MEM_WB_signals  = wb_q;
    assign ZF                 = zf_q;
    assign NF                 = nf_q;
    assign VF                 = vf_q;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Self-checking bench for ex_stage_unit: directed literal cases plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_ex_stage_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush;
    logic [15:0] pc_in;
    logic [17:0] mem_in;
    logic [7:0]  wb_in;
    logic [15:0] a_in, b_in;
    logic [3:0]  op_in;
    logic        zen_in, nven_in;
    logic [37:0] ex_in;

    logic [15:0] pc_o, alu_o;
    logic [17:0] mem_o;
    logic [7:0]  wb_o;
    logic        zf_o, nf_o, vf_o;

    int checks = 0;
    int errors = 0;

    assign ex_in = {a_in, b_in, op_in, zen_in, nven_in};

    always #5 clk = ~clk;

    ex_stage_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall              (stall),
        .flush              (flush),
        .ID_EX_PC_next      (pc_in),
        .ID_EX_EX_signals   (ex_in),
        .ID_EX_MEM_signals  (mem_in),
        .ID_EX_WB_signals   (wb_in),
        .EX_MEM_PC_next     (pc_o),
        .EX_MEM_ALU_out     (alu_o),
        .EX_MEM_MEM_signals (mem_o),
        .EX_MEM_WB_signals  (wb_o),
        .ZF                 (zf_o),
        .NF                 (nf_o),
        .VF                 (vf_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU from integer arithmetic; returns {V, result}.
    function automatic logic [16:0] model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        int sx, sy, s, t, sh;
        logic [15:0] r;
        logic v;
        sx = $signed(x);
        sy = $signed(y);
        sh = int'(y[3:0]);
        r  = '0;
        v  = 1'b0;
        case (o)
            4'd0, 4'd1: begin
                s = (o == 4'd0) ? sx + sy : sx - sy;
                if (s > 32767)       begin s = 32767;  v = 1'b1; end
                else if (s < -32768) begin s = -32768; v = 1'b1; end
                r = s[15:0];
            end
            4'd2: r = x ^ y;
            4'd3: begin
                s = 0;
                t = $signed(x[15:8]); s += t;
                t = $signed(y[15:8]); s += t;
                t = $signed(x[7:0]);  s += t;
                t = $signed(y[7:0]);  s += t;
                r = s[15:0];
            end
            4'd4: begin s = int'(x) * (1 << sh); r = s[15:0]; end
            4'd5: begin r = x; repeat (sh) r = {r[15], r[15:1]}; end
            4'd6: begin r = x; repeat (sh) r = {r[0], r[15:1]}; end
            4'd7: begin
                for (int i = 0; i < 4; i++) begin
                    logic [3:0] nx, ny;
                    nx = x[4*i +: 4];
                    ny = y[4*i +: 4];
                    s = $signed(nx);
                    t = $signed(ny);
                    s = s + t;
                    if (s > 7) s = 7;
                    else if (s < -8) s = -8;
                    r[4*i +: 4] = s[3:0];
                end
            end
            4'd8, 4'd9: begin s = int'(x) + int'(y); r = s[15:0]; end
            4'd10: r = {x[15:8], y[7:0]};
            4'd11: r = {y[7:0], x[7:0]};
            default: r = '0;
        endcase
        return {v, r};
    endfunction

    logic [15:0] m_pc = '0, m_alu = '0;
    logic [17:0] m_mem = '0;
    logic [7:0]  m_wb = '0;
    logic        m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;

    always begin
        logic [16:0] mr;
        @(posedge clk);
        mr = model(op_in, a_in, b_in);
        if (!rst_n) begin
            m_pc = '0; m_alu = '0; m_mem = '0; m_wb = '0;
            m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
        end else if (flush) begin
            m_pc = pc_in; m_alu = '0; m_mem = '0; m_wb = '0;
        end else if (!stall) begin
            m_pc = pc_in; m_alu = mr[15:0]; m_mem = mem_in; m_wb = wb_in;
            if (zen_in) m_z = (mr[15:0] == 16'h0000);
            if (nven_in) begin
                m_n = mr[15];
                m_v = mr[16];
            end
        end
        #1;
        check("model_pc",  32'(pc_o),  32'(m_pc));
        check("model_alu", 32'(alu_o), 32'(m_alu));
        check("model_mem", 32'(mem_o), 32'(m_mem));
        check("model_wb",  32'(wb_o),  32'(m_wb));
        check("model_zf",  32'(zf_o),  32'(m_z));
        check("model_nf",  32'(nf_o),  32'(m_n));
        check("model_vf",  32'(vf_o),  32'(m_v));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ex(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                          input logic ze, input logic ne);
        op_in = o; a_in = x; b_in = y; zen_in = ze; nven_in = ne;
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] exp);
        set_ex(o, x, y, 1'b1, 1'b1);
        tick();
        check(name, 32'(alu_o), 32'(exp));
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] edges [7];
        edges = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h0001, 16'h7777, 16'h8888};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 6)];
        return 16'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        pc_in = '0; mem_in = '0; wb_in = '0;
        set_ex(4'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick(); tick();
        check("reset_pc",  32'(pc_o),  32'h0);
        check("reset_alu", 32'(alu_o), 32'h0);
        check("reset_wb",  32'(wb_o),  32'h0);
        check("reset_flags", 32'({zf_o, nf_o, vf_o}), 32'h0);

        rst_n = 1'b1;
        pc_in = 16'h0002;
        run_op("add_pos_sat", 4'd0, 16'h7FFF, 16'h0001, 16'h7FFF);
        check("add_pos_flags", 32'({zf_o, nf_o, vf_o}), 32'b001);
        run_op("add_neg_sat", 4'd0, 16'h8000, 16'hFFFF, 16'h8000);
        check("add_neg_flags", 32'({zf_o, nf_o, vf_o}), 32'b011);
        run_op("sub_zero", 4'd1, 16'h1234, 16'h1234, 16'h0000);
        check("sub_zero_flags", 32'({zf_o, nf_o, vf_o}), 32'b100);
        set_ex(4'd2, 16'h00FF, 16'h0F0F, 1'b1, 1'b0);
        tick();
        check("xor_res", 32'(alu_o), 32'h0FF0);
        check("xor_flags", 32'({zf_o, nf_o, vf_o}), 32'b000);
        // Set N/V, then confirm a Z-only op leaves them alone.
        run_op("sub_neg_sat", 4'd1, 16'h8000, 16'h0001, 16'h8000);
        set_ex(4'd2, 16'h1234, 16'h1234, 1'b1, 1'b0);
        tick();
        check("z_only_flags", 32'({zf_o, nf_o, vf_o}), 32'b111);

        run_op("paddsb_pos", 4'd7, 16'h7777, 16'h1111, 16'h7777);
        run_op("paddsb_neg", 4'd7, 16'h8888, 16'hFFFF, 16'h8888);
        run_op("red",        4'd3, 16'h7F7F, 16'h7F7F, 16'h01FC);
        run_op("sra",        4'd5, 16'h8000, 16'h000F, 16'hFFFF);
        run_op("ror",        4'd6, 16'h0001, 16'h0001, 16'h8000);
        run_op("ror_zero",   4'd6, 16'hA5C3, 16'h0000, 16'hA5C3);
        run_op("llb",        4'd10, 16'hABCD, 16'h0012, 16'hAB12);
        run_op("lhb",        4'd11, 16'hABCD, 16'h0012, 16'h12CD);
        run_op("sw_wrap",    4'd9, 16'hFFFF, 16'h0002, 16'h0001);
        run_op("op_1110",    4'd14, 16'hFFFF, 16'hFFFF, 16'h0000);

        pc_in = 16'h1000; mem_in = 18'h2ABCD; wb_in = 8'h18;
        run_op("stall_setup", 4'd0, 16'h0003, 16'h0004, 16'h0007);
        stall = 1'b1;
        pc_in = 16'h1111; mem_in = 18'h00003; wb_in = 8'h3A;
        set_ex(4'd1, 16'h0005, 16'h0005, 1'b1, 1'b1);
        tick(); tick();
        check("stall_alu", 32'(alu_o), 32'h0007);
        check("stall_pc",  32'(pc_o),  32'h1000);
        check("stall_wb",  32'(wb_o),  32'h18);
        check("stall_flags", 32'({zf_o, nf_o, vf_o}), 32'b000);
        flush = 1'b1; pc_in = 16'h2000;
        tick();
        check("flush_alu", 32'(alu_o), 32'h0);
        check("flush_mem", 32'(mem_o), 32'h0);
        check("flush_wb",  32'(wb_o),  32'h0);
        check("flush_pc",  32'(pc_o),  32'h2000);
        check("flush_flags", 32'({zf_o, nf_o, vf_o}), 32'b000);
        stall = 1'b0; flush = 1'b0;

        wb_in = 8'h38; pc_in = 16'h3000;
        run_op("pre_reset_sub", 4'd1, 16'h0001, 16'h0001, 16'h0000);
        rst_n = 1'b0;
        #3;
        check("reset_sync_zf", 32'(zf_o), 32'h1);
        tick();
        check("midreset_pc",  32'(pc_o),  32'h0);
        check("midreset_wb",  32'(wb_o),  32'h0);
        check("midreset_flags", 32'({zf_o, nf_o, vf_o}), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            stall   = ($urandom_range(0, 4) == 0);
            flush   = ($urandom_range(0, 9) == 0);
            pc_in   = 16'($urandom);
            mem_in  = 18'($urandom);
            wb_in   = 8'($urandom);
            set_ex(4'($urandom_range(0, 15)), pick(), pick(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
